instruction_field_encoder: RTL

Packs immediates and PC-relative byte offsets back into SPARC V8 instruction words. It is the inverse of the datapath's immediate sign-extend/shift stage, which turns simm13, imm22, disp22 and disp30 fields into 32-bit operands. It sits in the boot/self-test program generator, takes one request per handshake, and emits one or two encoded instruction words on a valid/ready stream. Unrepresentable requests produce a single error beat.

---
 rtl/sparc_isa_pkg.sv | 32 +++
 rtl/instruction_field_encoder_if.sv | 27 ++
 rtl/ir_field_packer.sv | 63 ++++++
 rtl/instruction_field_encoder.sv | 99 +++++++++
 4 files changed

// File: rtl/sparc_isa_pkg.sv
// SPARC V8 opcode field constants and shared types for the instruction field encoder.
package sparc_isa_pkg;

  localparam logic [1:0] OP_CALL         = 2'b01;
  localparam logic [1:0] OP_BRANCH_SETHI = 2'b00;
  localparam logic [1:0] OP_ARITH        = 2'b10;
  localparam logic [2:0] OP2_SETHI       = 3'b100;
  localparam logic [2:0] OP2_BICC        = 3'b010;
  localparam logic [5:0] OP3_OR          = 6'b000010;

  typedef enum logic [1:0] {
    KIND_SET    = 2'd0,
    KIND_SETHI  = 2'd1,
    KIND_BRANCH = 2'd2,
    KIND_CALL   = 2'd3
  } req_kind_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StEmit1 = 2'd1,
    StEmit2 = 2'd2
  } state_e;

  typedef struct packed {
    req_kind_e   kind;
    logic [31:0] value;
    logic [4:0]  rd;
    logic [3:0]  cond;
    logic        annul;
  } req_t;

endpackage

// File: rtl/instruction_field_encoder_if.sv
// Request stream in, encoded instruction word stream out.
interface instruction_field_encoder_if;

  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [31:0] req_value;
  logic [4:0]  req_rd;
  logic [3:0]  req_cond;
  logic        req_annul;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ir;
  logic        out_last;
  logic        out_err;

  modport master (
    output req_valid, req_kind, req_value, req_rd, req_cond, req_annul, out_ready,
    input  req_ready, out_valid, out_ir, out_last, out_err
  );

  modport slave (
    input  req_valid, req_kind, req_value, req_rd, req_cond, req_annul, out_ready,
    output req_ready, out_valid, out_ir, out_last, out_err
  );

endinterface

// File: rtl/ir_field_packer.sv
// Combinational packer: builds the instruction word for one beat of a request and
// reports whether the request is representable and whether it needs two words.
module ir_field_packer
  import sparc_isa_pkg::*;
(
  input  req_t        i_req,
  input  logic        i_beat,
  output logic [31:0] o_ir,
  output logic        o_legal,
  output logic        o_two_word
);

  logic        w_fits_simm13;
  logic        w_low10_zero;
  logic        w_word_aligned;
  logic        w_fits_disp22;
  logic [31:0] w_sethi;
  logic [31:0] w_or_imm;
  logic [31:0] w_or_low;

  assign w_fits_simm13  = (&i_req.value[31:12]) | ~(|i_req.value[31:12]);
  assign w_low10_zero   = ~(|i_req.value[9:0]);
  assign w_word_aligned = ~(|i_req.value[1:0]);
  assign w_fits_disp22  = (&i_req.value[31:23]) | ~(|i_req.value[31:23]);

  assign w_sethi  = {OP_BRANCH_SETHI, i_req.rd, OP2_SETHI, i_req.value[31:10]};
  assign w_or_imm = {OP_ARITH, i_req.rd, OP3_OR, 5'd0, 1'b1, i_req.value[12:0]};
  assign w_or_low = {OP_ARITH, i_req.rd, OP3_OR, i_req.rd, 1'b1, 3'b000, i_req.value[9:0]};

  always_comb begin
    o_ir       = '0;
    o_legal    = 1'b1;
    o_two_word = 1'b0;
    unique case (i_req.kind)
      KIND_SET: begin
        if (w_fits_simm13) begin
          o_ir = w_or_imm;
        end else if (w_low10_zero) begin
          o_ir = w_sethi;
        end else begin
          o_two_word = 1'b1;
          o_ir       = i_beat ? w_or_low : w_sethi;
        end
      end
      KIND_SETHI: begin
        if (w_low10_zero) o_ir = w_sethi;
        else              o_legal = 1'b0;
      end
      KIND_BRANCH: begin
        if (w_word_aligned && w_fits_disp22) begin
          o_ir = {OP_BRANCH_SETHI, i_req.annul, i_req.cond, OP2_BICC, i_req.value[23:2]};
        end else begin
          o_legal = 1'b0;
        end
      end
      KIND_CALL: begin
        if (w_word_aligned) o_ir = {OP_CALL, i_req.value[31:2]};
        else                o_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instruction_field_encoder.sv
// Accepts immediate/offset packing requests and streams out one or two SPARC V8
// instruction words (or a single error beat) per request.
module instruction_field_encoder
  import sparc_isa_pkg::*;
(
  input logic                        clk,
  input logic                        reset_n,
  instruction_field_encoder_if.slave bus
);

  state_e      r_state, w_state_d;
  req_t        r_req, w_req_in, w_pk_req;
  logic        r_out_valid, w_out_valid_d;
  logic        r_out_last, w_out_last_d;
  logic        r_out_err, w_out_err_d;
  logic [31:0] r_out_ir, w_out_ir_d;
  logic [31:0] w_pk_ir;
  logic        w_pk_legal, w_pk_two_word, w_pk_beat;
  logic        w_out_hs, w_req_ready, w_accept;

  assign w_req_in = '{kind:  req_kind_e'(bus.req_kind),
                      value: bus.req_value,
                      rd:    bus.req_rd,
                      cond:  bus.req_cond,
                      annul: bus.req_annul};

  assign w_out_hs    = r_out_valid & bus.out_ready;
  assign w_req_ready = (r_state == StIdle) | (w_out_hs & r_out_last);
  assign w_accept    = bus.req_valid & w_req_ready;

  // One packer serves both beats: a fresh request gets beat 0, the held one beat 1.
  assign w_pk_req  = w_accept ? w_req_in : r_req;
  assign w_pk_beat = ~w_accept;

  ir_field_packer u_packer (
    .i_req      (w_pk_req),
    .i_beat     (w_pk_beat),
    .o_ir       (w_pk_ir),
    .o_legal    (w_pk_legal),
    .o_two_word (w_pk_two_word)
  );

  always_comb begin
    w_state_d     = r_state;
    w_out_valid_d = r_out_valid;
    w_out_ir_d    = r_out_ir;
    w_out_last_d  = r_out_last;
    w_out_err_d   = r_out_err;
    if (w_out_hs) w_out_valid_d = 1'b0;
    if (w_accept) begin
      w_state_d     = StEmit1;
      w_out_valid_d = 1'b1;
      w_out_ir_d    = w_pk_ir;
      w_out_last_d  = ~w_pk_two_word;
      w_out_err_d   = ~w_pk_legal;
    end else if (w_out_hs) begin
      case (r_state)
        StEmit1: begin
          // A non-last first beat can only be the SETHI half of a two-word SET.
          if (!r_out_last) begin
            w_state_d     = StEmit2;
            w_out_valid_d = 1'b1;
            w_out_ir_d    = w_pk_ir;
            w_out_last_d  = 1'b1;
            w_out_err_d   = 1'b0;
          end else begin
            w_state_d = StIdle;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_req       <= '0;
      r_out_valid <= 1'b0;
      r_out_ir    <= '0;
      r_out_last  <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_out_valid <= w_out_valid_d;
      r_out_ir    <= w_out_ir_d;
      r_out_last  <= w_out_last_d;
      r_out_err   <= w_out_err_d;
      if (w_accept) r_req <= w_req_in;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_ir    = r_out_ir;
  assign bus.out_last  = r_out_last;
  assign bus.out_err   = r_out_err;

endmodule
